// File: rtl/deinterleaver.sv
// ============================================================================
// deinterleaver : ping-pong QPP block deinterleaver (K = 1056 or 6144)
// Revision 1.0
// ============================================================================
`default_nettype none

module deinterleaver #(
    parameter int K_SMALL = 1056,
    parameter int K_LARGE = 6144,
    parameter int AW      = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic data_in,
    input  logic in_valid,
    input  logic blk_start,
    input  logic blk_size,
    output logic in_ready,
    output logic data_out,
    output logic out_valid,
    output logic out_start,
    output logic out_end,
    output logic err
);

    localparam logic [0:0] c_W_IDLE = 1'b0;
    localparam logic [0:0] c_W_FILL = 1'b1;
    localparam logic [0:0] c_R_IDLE = 1'b0;
    localparam logic [0:0] c_R_DRAIN = 1'b1;

    localparam logic [AW-1:0] c_K_S  = AW'(K_SMALL);
    localparam logic [AW-1:0] c_K_L  = AW'(K_LARGE);
    // First-step values: pi(1) = g(0) = f1+f2, g(1) = f1+3*f2, step of g = 2*f2
    localparam logic [AW-1:0] c_PI1_S = AW'((17 + 66) % K_SMALL);
    localparam logic [AW-1:0] c_G1_S  = AW'((17 + 3 * 66) % K_SMALL);
    localparam logic [AW-1:0] c_D_S   = AW'((2 * 66) % K_SMALL);
    localparam logic [AW-1:0] c_PI1_L = AW'((263 + 480) % K_LARGE);
    localparam logic [AW-1:0] c_G1_L  = AW'((263 + 3 * 480) % K_LARGE);
    localparam logic [AW-1:0] c_D_L   = AW'((2 * 480) % K_LARGE);

    function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                              input logic [AW-1:0] b,
                                              input logic [AW-1:0] k);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k})
            s = s - {1'b0, k};
        return s[AW-1:0];
    endfunction

    logic [0:0]    r_wstate, w_wstate_nxt;
    logic [0:0]    r_rstate, w_rstate_nxt;
    logic          r_wbank, r_rbank;
    logic [1:0]    r_full;
    logic [AW-1:0] r_klat [2];
    logic [AW-1:0] r_wk, r_d, r_pi, r_g, r_cnt, r_raddr;
    logic          r_data_out, r_out_valid, r_out_start, r_out_end, r_err;
    logic          r_mem0 [K_LARGE];
    logic          r_mem1 [K_LARGE];

    logic          w_acc, w_start, w_fill, w_wlast, w_we, w_drain, w_rlast, w_rbit;
    logic [AW-1:0] w_waddr;

    assign in_ready  = ~r_full[r_wbank];
    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign out_start = r_out_start;
    assign out_end   = r_out_end;
    assign err       = r_err;

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wstate <= c_W_IDLE;
            r_rstate <= c_R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_rstate_nxt = r_rstate;
        if (w_start)
            w_wstate_nxt = c_W_FILL;
        else if (w_wlast)
            w_wstate_nxt = c_W_IDLE;
        case (r_rstate)
            c_R_IDLE:  if (r_full[r_rbank]) w_rstate_nxt = c_R_DRAIN;
            c_R_DRAIN: if (w_rlast) w_rstate_nxt = r_full[~r_rbank] ? c_R_DRAIN : c_R_IDLE;
            default:   w_rstate_nxt = c_R_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_acc   = in_valid & in_ready;
        w_start = w_acc & blk_start;
        w_fill  = w_acc & ~blk_start & (r_wstate == c_W_FILL);
        w_wlast = w_fill & (r_cnt == r_wk - 1'b1);
        w_we    = w_start | w_fill;
        w_waddr = w_start ? '0 : r_pi;
        w_drain = (r_rstate == c_R_DRAIN);
        w_rlast = w_drain & (r_raddr == r_klat[r_rbank] - 1'b1);
        w_rbit  = r_rbank ? r_mem1[r_raddr] : r_mem0[r_raddr];
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            if (r_wbank)
                r_mem1[w_waddr] <= data_in;
            else
                r_mem0[w_waddr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wbank     <= 1'b0;
            r_rbank     <= 1'b0;
            r_full      <= 2'b00;
            r_klat[0]   <= '0;
            r_klat[1]   <= '0;
            r_wk        <= '0;
            r_d         <= '0;
            r_pi        <= '0;
            r_g         <= '0;
            r_cnt       <= '0;
            r_raddr     <= '0;
            r_data_out  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_start <= 1'b0;
            r_out_end   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // A start always restarts the fill, abandoning any partial block
            if (w_start) begin
                r_wk  <= blk_size ? c_K_L : c_K_S;
                r_d   <= blk_size ? c_D_L : c_D_S;
                r_pi  <= blk_size ? c_PI1_L : c_PI1_S;
                r_g   <= blk_size ? c_G1_L : c_G1_S;
                r_cnt <= AW'(1);
            end else if (w_wlast) begin
                r_full[r_wbank] <= 1'b1;
                r_klat[r_wbank] <= r_wk;
                r_wbank         <= ~r_wbank;
            end else if (w_fill) begin
                r_pi  <= mod_add(r_pi, r_g, r_wk);
                r_g   <= mod_add(r_g, r_d, r_wk);
                r_cnt <= r_cnt + 1'b1;
            end

            // Writer and reader always own different banks, so set/clear never collide
            if (w_rlast) begin
                r_full[r_rbank] <= 1'b0;
                r_rbank         <= ~r_rbank;
            end
            if (w_drain)
                r_raddr <= w_rlast ? '0 : r_raddr + 1'b1;

            r_data_out  <= w_drain & w_rbit;
            r_out_valid <= w_drain;
            r_out_start <= w_drain & (r_raddr == '0);
            r_out_end   <= w_rlast;
            r_err       <= w_acc & blk_start & (r_wstate == c_W_FILL);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_deinterleaver.sv
// ============================================================================
// tb_deinterleaver : directed self-checking bench with a QPP reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_deinterleaver;

    logic clk = 1'b0;
    logic reset, data_in, in_valid, blk_start, blk_size;
    logic in_ready, data_out, out_valid, out_start, out_end, err;

    int total = 0;
    int bad   = 0;

    deinterleaver dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .blk_start (blk_start),
        .blk_size  (blk_size),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_start (out_start),
        .out_end   (out_end),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Direct closed-form QPP, independent of the incremental hardware recurrence
    function automatic int qpp(input int k, input int i);
        longint f1, f2, li;
        f1 = (k == 1056) ? 263 - 246 : 263;
        f2 = (k == 1056) ? 66 : 480;
        li = i;
        return int'((f1 * li + f2 * li * li) % longint'(k));
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model and per-cycle compare
    logic [2:0] exp_q[$];
    bit         cur_q[$];
    bit         filling = 0;
    int         cur_k   = 0;
    bit         exp_err = 0;
    bit         saw_stall = 0;
    int         err_cnt = 0;
    int         pos = 0, ones = 0, one_pos = -1, blk_cnt = 0;
    int         blk_ones [64];
    int         blk_pos  [64];
    int         blk_len  [64];

    always @(negedge clk) begin
        bit         ob [6144];
        logic [2:0] e;
        if (!reset) begin
            exp_q.delete();
            cur_q.delete();
            filling = 0;
            exp_err = 0;
            check("reset_outputs_zero", {out_valid, data_out, out_start, out_end, err}, 0);
        end else begin
            check("err", err, exp_err);
            if (err) err_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_bits{data,start,end}", {data_out, out_start, out_end}, e);
                end
                if (out_start) begin pos = 0; ones = 0; one_pos = -1; end
                if (data_out) begin ones++; one_pos = pos; end
                if (out_end && blk_cnt < 64) begin
                    blk_ones[blk_cnt] = ones;
                    blk_pos[blk_cnt]  = one_pos;
                    blk_len[blk_cnt]  = pos + 1;
                    blk_cnt++;
                end
                pos++;
            end else if (data_out || out_start || out_end) begin
                check("idle_outputs_zero", {data_out, out_start, out_end}, 0);
            end

            exp_err = 0;
            if (in_valid && !in_ready) saw_stall = 1;
            if (in_valid && in_ready) begin
                if (blk_start) begin
                    if (filling) exp_err = 1;
                    filling = 1;
                    cur_k = blk_size ? 6144 : 1056;
                    cur_q.delete();
                    cur_q.push_back(data_in);
                end else if (filling) begin
                    cur_q.push_back(data_in);
                    if (cur_q.size() == cur_k) begin
                        for (int i = 0; i < cur_k; i++) ob[qpp(cur_k, i)] = cur_q[i];
                        for (int p = 0; p < cur_k; p++)
                            exp_q.push_back({ob[p], p == 0, p == cur_k - 1});
                        filling = 0;
                    end
                end
            end
        end
    end

    // Stimulus
    bit blk_bits [6144];

    task automatic drive_bit(input logic d, input logic st, input logic sz);
        int n;
        n = 0;
        data_in = d; blk_start = st; blk_size = sz; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            $display("FAIL in_ready_timeout: got stalled expected accept");
            $fatal(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic sz, input int nbits);
        for (int i = 0; i < nbits; i++) drive_bit(blk_bits[i], i == 0, sz);
    endtask

    task automatic fill_lone(input int k, input int idx);
        for (int i = 0; i < k; i++) blk_bits[i] = (i == idx);
    endtask

    task automatic fill_rand(input int k);
        for (int i = 0; i < k; i++) blk_bits[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; blk_start = 1'b0; data_in = 1'b0; blk_size = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_timeout", int'(n >= 20000), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b0, e0;
        reset = 1'b0;
        idle_inputs();
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_err", err, 0);
        check("model_pi_1056_1", qpp(1056, 1), 83);
        check("model_pi_1056_2", qpp(1056, 2), 298);
        check("model_pi_6144_1", qpp(6144, 1), 743);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Lone-one blocks pin the permutation positions
        fill_lone(1056, 1); send_block(1'b0, 1056); idle_inputs(); wait_idle();
        check("lone_1056_b1_ones", blk_ones[0], 1);
        check("lone_1056_b1_pos", blk_pos[0], 83);
        fill_lone(1056, 2); send_block(1'b0, 1056); idle_inputs(); wait_idle();
        check("lone_1056_b2_pos", blk_pos[1], 298);
        check("lone_1056_len", blk_len[1], 1056);
        fill_lone(6144, 1); send_block(1'b1, 6144); idle_inputs(); wait_idle();
        check("lone_6144_b1_pos", blk_pos[2], 743);
        check("lone_6144_len", blk_len[2], 6144);

        // Back-to-back random blocks with mixed sizes; the last one queues behind the long drain
        saw_stall = 0;
        fill_rand(1056); send_block(1'b0, 1056);
        fill_rand(6144); send_block(1'b1, 6144);
        fill_rand(1056); send_block(1'b0, 1056);
        fill_rand(1056); send_block(1'b0, 1056);
        idle_inputs(); wait_idle();
        check("stream_blocks", blk_cnt, 7);
        check("stall_seen", int'(saw_stall), 1);

        // Restart mid-block: exactly one err pulse, only the restarted block emerges
        e0 = err_cnt; b0 = blk_cnt;
        fill_rand(1056); send_block(1'b0, 500);
        fill_rand(1056); send_block(1'b0, 1056);
        idle_inputs(); wait_idle();
        check("restart_err_pulses", err_cnt - e0, 1);
        check("restart_blocks_out", blk_cnt - b0, 1);

        // Reset mid-block while the previous block is still draining
        fill_rand(6144); send_block(1'b1, 6144);
        fill_rand(6144); send_block(1'b1, 3000);
        check("draining_before_reset", out_valid, 1);
        reset = 1'b0;
        #1;
        check("async_reset_out_valid", out_valid, 0);
        check("async_reset_in_ready", in_ready, 1);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        b0 = blk_cnt;
        fill_rand(1056); send_block(1'b0, 1056); idle_inputs(); wait_idle();
        check("post_reset_blocks_out", blk_cnt - b0, 1);
        check("post_reset_len", blk_len[blk_cnt - 1], 1056);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
